// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic sequencer:
// operator codes, sequencer states and the sign-magnitude limit.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_CONV,
        ST_DONE
    } state_t;

    // Largest magnitude representable in a w-bit sign-magnitude word.
    function automatic longint sm_limit(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    localparam int     DEF_WIDTH = 16;
    localparam longint SM_MAX    = sm_limit(DEF_WIDTH);

endpackage

// File: rtl/sm_convert.sv
// Saturating conversion of a sign plus wide magnitude into a
// WIDTH-bit sign-magnitude word; zero never carries a sign.
module sm_convert
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               sign_i,
    input  logic [2*WIDTH-1:0] mag_i,
    output logic [WIDTH-1:0]   sm_o,
    output logic               ovf_o
);

    localparam logic [2*WIDTH-1:0] LIMIT = (2*WIDTH)'(sm_limit(WIDTH));

    // Clamp oversized magnitudes and suppress negative zero.
    always_comb begin
        sm_o  = '0;
        ovf_o = (mag_i > LIMIT);
        if (mag_i == '0) begin
            sm_o = '0;
        end else if (ovf_o) begin
            sm_o = {sign_i, {(WIDTH-1){1'b1}}};
        end else begin
            sm_o = {sign_i, mag_i[WIDTH-2:0]};
        end
    end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle add/sub/shift-add-multiply sequencer around one
// shared adder, returning a saturated sign-magnitude result.
module calc_alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             err
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [AW-1:0]    mcand_q, mcand_d, mplier_q, mplier_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d, err_q, err_d;

    logic             legal, is_mul, is_sub;
    logic [AW-1:0]    a_ext, b_ext;
    logic [AW-1:0]    add_x, add_y, add_sum;
    logic             add_cin;
    logic             conv_sign;
    logic [AW-1:0]    conv_mag;
    logic [WIDTH-1:0] conv_sm;
    logic             conv_ovf;

    assign legal  = (op_sel == OP_ADD) || (op_sel == OP_SUB) ||
                    (op_sel == OP_MUL);
    assign is_mul = (op_q == OP_MUL);
    assign is_sub = (op_q == OP_SUB);
    assign a_ext  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext  = {{WIDTH{b_q[WIDTH-1]}}, b_q};

    // Shared adder: accumulates partial products or forms a+b / a-b.
    always_comb begin
        add_x   = is_mul ? acc_q : a_ext;
        add_y   = '0;
        add_cin = 1'b0;
        if (is_mul) begin
            add_y = mplier_q[0] ? mcand_q : '0;
        end else if (is_sub) begin
            add_y   = ~b_ext;
            add_cin = 1'b1;
        end else begin
            add_y = b_ext;
        end
        add_sum = add_x + add_y + AW'(add_cin);
    end

    // Sign and magnitude of the finished value for the converter.
    always_comb begin
        conv_sign = is_mul ? (sign_a_q ^ sign_b_q) : acc_q[AW-1];
        conv_mag  = acc_q;
        if (!is_mul && acc_q[AW-1]) begin
            conv_mag = ~acc_q + AW'(1);
        end
    end

    sm_convert #(
        .WIDTH (WIDTH)
    ) u_conv (
        .sign_i (conv_sign),
        .mag_i  (conv_mag),
        .sm_o   (conv_sm),
        .ovf_o  (conv_ovf)
    );

    // Next-state and datapath sequencing.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d  = op_a;
                    b_d  = op_b;
                    op_d = op_sel;
                    if (legal) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d    = ST_DONE;
                        err_d      = 1'b1;
                        result_d   = '0;
                        overflow_d = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                sign_a_d = a_q[WIDTH-1];
                sign_b_d = b_q[WIDTH-1];
                mcand_d  = a_q[WIDTH-1] ? (~a_ext + AW'(1)) : a_ext;
                mplier_d = b_q[WIDTH-1] ? (~b_ext + AW'(1)) : b_ext;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                if (!is_mul) begin
                    acc_d   = add_sum;
                    state_d = ST_CONV;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d = ST_CONV;
                end else begin
                    acc_d    = add_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            ST_CONV: begin
                result_d   = conv_sm;
                overflow_d = conv_ovf;
                err_d      = 1'b0;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed and randomized bench for calc_alu_sequencer against an
// integer-arithmetic reference model.
module tb_calc_alu_sequencer;

    logic        clk;
    logic        nRST;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_sel;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    calc_alu_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_sel   (op_sel),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, then saturating sign-magnitude.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [2:0] sel,
                                  output logic [15:0] r, output logic ov,
                                  output logic er, output int lat);
        longint va;
        longint vb;
        longint v;
        longint mag;
        logic   neg;
        va  = longint'($signed(a));
        vb  = longint'($signed(b));
        v   = 0;
        r   = 16'h0000;
        ov  = 1'b0;
        er  = 1'b0;
        lat = 3;
        case (sel)
            3'b001: v = va + vb;
            3'b010: v = va - vb;
            3'b100: begin v = va * vb; lat = 19; end
            default: begin er = 1'b1; lat = 0; end
        endcase
        if (!er) begin
            neg = (v < 0);
            mag = neg ? -v : v;
            if (mag == 0) begin
                r = 16'h0000;
            end else if (mag > 32767) begin
                ov = 1'b1;
                r  = {neg, 15'h7fff};
            end else begin
                r = {neg, mag[14:0]};
            end
        end
    endfunction

    // Issue one operation from a negedge and check its completion.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] sel, input bit poke);
        logic [15:0] er_res;
        logic        er_ov;
        logic        er_err;
        int          exp_lat;
        int          lat;
        bit          got;
        int          extra;
        model(a, b, sel, er_res, er_ov, er_err, exp_lat);
        op_a   = a;
        op_b   = b;
        op_sel = sel;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = 16'($urandom);
        op_b   = 16'($urandom);
        op_sel = 3'($urandom);
        got = 1'b0;
        lat = -1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            start = (poke && c == 1);
            if (done) begin
                got = 1'b1;
                lat = c;
            end
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("result", result, er_res);
        check("overflow", overflow, er_ov);
        check("err", err, er_err);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        check("result_hold", result, er_res);
        if (poke) begin
            extra = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("single_done", extra, 0);
        end
    endtask

    logic [2:0] ill [5];
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  rs;
    int          pick;

    initial begin
        ill = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        nRST   = 1'b0;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_sel = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err, 0);
        nRST = 1'b1;
        @(negedge clk);

        run_op(16'd11, 16'd23, 3'b001, 0);
        check("add_11_23", result, 16'h0022);
        run_op(16'd3, 16'd5, 3'b010, 0);
        check("sub_3_5", result, 16'h8002);
        run_op(16'h8000, 16'h7fff, 3'b001, 0);
        check("add_min_max", result, 16'h8001);
        run_op(-16'sd3, -16'sd6, 3'b100, 0);
        check("mul_m3_m6", result, 16'h0012);
        run_op(-16'sd12, 16'd3000, 3'b100, 0);
        check("mul_ovf", result, 16'hffff);
        run_op(16'h8000, 16'd1, 3'b100, 0);
        check("mul_min_1", result, 16'hffff);
        run_op(16'd1, 16'd1, 3'b010, 0);
        check("no_neg_zero", result, 16'h0000);
        run_op(16'd0, -16'sd7, 3'b100, 0);
        run_op(16'h8000, 16'h8000, 3'b001, 0);
        run_op(16'd100, 16'd200, 3'b011, 0);
        check("illegal_err", err, 1);
        run_op(16'd9, 16'd4, 3'b001, 1);

        for (int i = 0; i < 40; i++) begin
            ra   = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                : 16'($urandom_range(0, 400) - 200);
            rb   = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                : 16'($urandom_range(0, 400) - 200);
            pick = $urandom_range(0, 9);
            if (pick < 3)      rs = 3'b001;
            else if (pick < 6) rs = 3'b010;
            else if (pick < 9) rs = 3'b100;
            else               rs = ill[$urandom_range(0, 4)];
            run_op(ra, rb, rs, 0);
        end

        run_op(16'd5, 16'd5, 3'b001, 0);
        op_a   = 16'd100;
        op_b   = 16'd200;
        op_sel = 3'b100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_mul_busy", busy, 1);
        nRST = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_overflow", overflow, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        run_op(16'd4, 16'd3, 3'b001, 0);
        check("post_rst_add", result, 16'h0007);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_alu_sequencer.md
Name: calc_alu_sequencer

Overview:
- Multi-cycle arithmetic controller between the calculator front-end FSM (operand entry, equal key) and the display path.
- Accepts two two's-complement operands and a one-hot operator, then sequences a single shared adder to perform add, subtract, or shift-add multiply.
- Returns a sign-magnitude result (bit 15 = sign, bits 14:0 = magnitude) in the format the display driver consumes, with a one-cycle completion pulse.

Parameters:
- WIDTH, 16, operand and result width in bits; sign-magnitude magnitude field is WIDTH-1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op_a  in  WIDTH  operand 1, two's complement.
- op_b  in  WIDTH  operand 2, two's complement.
- op_sel  in  3  one-hot operator: 001 add, 010 sub, 100 mul.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse; result, overflow and err are valid in that cycle.
- result  out  WIDTH  sign-magnitude result, held until the next DONE.
- overflow  out  1  true magnitude exceeded 2^(WIDTH-1)-1; result is saturated.
- err  out  1  op_sel was not one of the three legal codes.

Behaviour:
- Clock and reset: one clock domain. nRST low asynchronously forces IDLE, busy=0, done=0, result=0, overflow=0, err=0, and clears all internal registers, including mid-operation.
- States: IDLE, LOAD, EXEC, CONV, DONE.
- IDLE:
  - start=1 at edge N → LOAD; op_a, op_b and op_sel are captured at that edge.
  - Illegal op_sel → DONE directly with err=1, result=0, overflow=0.
- LOAD: computes sign_a/sign_b and 17-bit magnitudes (so -32768 is handled), and clears the accumulator and iteration counter. → EXEC.
- EXEC:
  - Add/sub: one cycle. Computes the 17-bit signed sum a+b or a-b. → CONV.
  - Mul: WIDTH iterations, one per cycle. Each iteration adds the shifted |a| into the 2*WIDTH-bit accumulator when the current bit of |b| is 1, then shifts. A 5-bit counter terminates the loop after WIDTH cycles. → CONV.
- CONV:
  - Converts to sign-magnitude.
  - Mul sign = sign_a XOR sign_b.
  - If |value| > 2^(WIDTH-1)-1: overflow=1 and result = {sign, all-ones magnitude}.
  - Zero always encodes as 0x0000 (no negative zero). → DONE.
- DONE: done=1 and result/overflow/err are registered. → IDLE on the next edge.
- Latency from the start-accept edge N:
  - Add/sub: done is high in the cycle after edge N+3.
  - Mul: done is high in the cycle after edge N+3+WIDTH (N+19 for WIDTH=16).
  - Illegal op: done is high in the cycle after edge N.
- start while busy is ignored and not queued. start held high continuously re-triggers from IDLE on the edge after DONE.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- overflow and err change only in DONE.

Decomposition:
- Package calc_pkg holds:
  - OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b100.
  - An enumerated state type for IDLE/LOAD/EXEC/CONV/DONE.
  - The SM_MAX constant (2^(WIDTH-1)-1).
- One sub-module, sm_convert: combinational conversion from signed/magnitude input to saturating sign-magnitude, producing the overflow flag. The sequencer instantiates it in the CONV path.

Test Plan:
- op_a=11, op_b=23, op_sel=001, start pulse → done 4 cycles after accept, result=0x0022, overflow=0, busy low the following cycle.
- op_a=3, op_b=5, op_sel=010 → result=0x8002; op_a=-32768, op_b=32767, add → result=0x8001.
- op_a=-3, op_b=-6, op_sel=100 → done 20 cycles after accept, result=0x0012; op_a=-12, op_b=3000 mul → overflow=1, result=0xFFFF.
- op_a=-32768, op_b=1, mul → overflow=1, result=0xFFFF; op_a=1, op_b=1, sub → result=0x0000 (no negative zero).
- op_sel=011 with start → done in the next cycle, err=1, result=0x0000; a second start pulse during busy in an add → ignored, exactly one done.
- Assert nRST at iteration 8 of a multiply → busy/done/result cleared immediately; a subsequent 4+3 add completes normally with result=0x0007.
